lottery_arbiter: RTL and testbench
==================================

Name: lottery_arbiter

Overview:
- AHB-style bus arbiter for 4 masters. It shares the bus using the four 4-bit lottery tickets from the ticket generator; each ticket slot maps to one master.
- Sits between the masters' request lines and the bus mux/decoder. It drives the one-hot grant, the master number and the master-lock indicators.
- Starvation guard: any master that waits too long wins regardless of its ticket.

Parameters:
- MAX_TENURE, 8, cycles (counted on hready=1) a non-locked owner keeps the bus while others request.
- STARVE_LIMIT, 12, wait cycles after which a requesting master is forced to win.
- WAIT_W, 4, width of each per-master wait counter; must satisfy STARVE_LIMIT < 2^WAIT_W.
- DEFAULT_MASTER, 0, master granted when no one requests.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- t0  input  4  ticket for master 0 (changes on negedge clk, stable at posedge).
- t1  input  4  ticket for master 1.
- t2  input  4  ticket for master 2.
- t3  input  4  ticket for master 3.
- hbusreq  input  4  bus request, bit i = master i.
- hlock  input  4  locked-transfer request, bit i = master i.
- hready  input  1  transfer-done from the bus; handover only when 1.
- hgrant  output  4  one-hot grant, registered.
- hmaster  output  2  index of the master owning the address phase, registered.
- hmastlock  output  1  current address phase is locked, registered.

Behaviour:
- Reset (reset=0, async): hgrant=1<<DEFAULT_MASTER, hmaster=DEFAULT_MASTER, hmastlock=0, state=IDLE, tenure=0, all wait counters=0.
- Lottery winner (combinational, among hbusreq=1):
  - If any requesting master has wait >= STARVE_LIMIT, the lowest-index such master wins.
  - Otherwise the requester with the largest ticket wins; ties go to the lowest index.
  - If no master requests, the winner is DEFAULT_MASTER.
- FSM states: IDLE, OWN, LOCKED. The owner is the index of hgrant. All transitions are gated by hready=1; with hready=0, the state, hgrant, hmaster, hmastlock and tenure hold.
- IDLE:
  - Any hbusreq -> hgrant=winner, tenure=0, go to OWN (or LOCKED if hlock[winner]).
  - Else stay in IDLE with the default grant.
- OWN:
  - hlock[owner]=1 -> LOCKED, grant held.
  - hbusreq[owner]=0 -> re-arbitrate. Any request -> OWN with the new winner; none -> IDLE with the default master.
  - Tenure reaches MAX_TENURE-1 while another master requests -> re-arbitrate; the owner may win again by lottery.
  - Else tenure++ (saturating).
- LOCKED:
  - Grant held unconditionally while hlock[owner]=1; the tenure limit and starvation are ignored.
  - hlock[owner] drops -> tenure=0, go to OWN.
- Grant latency: request sampled at posedge N; hgrant is visible after posedge N, at the earliest, when hready=1.
- hmaster/hmastlock: on posedge with hready=1, hmaster<=index(hgrant) and hmastlock<=hlock[index(hgrant)] & (state==LOCKED). This gives a one-cycle lag behind hgrant, per AHB address-phase handover.
- Wait counters:
  - Each posedge, wait[i]++ (saturating at 2^WAIT_W-1) if hbusreq[i]=1 and hgrant[i]=0.
  - wait[i] is cleared when master i is granted or drops its request.
  - The counters advance regardless of hready.
- Simultaneous events:
  - The owner dropping its request and tenure expiry in the same cycle are treated as a drop.
  - A new winner is computed from the same-cycle tickets.
- hgrant is always exactly one-hot. No cycle may show zero grants or two grants.

Decomposition:
- Shared package (ahb_arb_pkg) holds:
  - state encoding localparams ST_IDLE=2'd0, ST_OWN=2'd1, ST_LOCKED=2'd2;
  - NUM_MASTERS=4 and TICKET_W=4.
- One natural sub-module: lottery_pick. It is purely combinational: it takes the tickets, hbusreq, the wait counters and STARVE_LIMIT, and returns the winner index plus an any_req flag.
- The FSM, tenure counter, wait counters and output registers stay in lottery_arbiter.

Test Plan:
- Reset mid-burst:
  - Stimulus: assert reset=0 while master 2 owns in LOCKED.
  - Response: hgrant=4'b0001, hmaster=0, hmastlock=0 immediately (async); the grant stays at master 0 until requests arrive after release.
- Ticket decides:
  - Stimulus: hbusreq=4'b1010, t1=5, t3=9, hready=1.
  - Response: hgrant=4'b1000 next posedge; hmaster=3 one cycle later.
- Tie-break:
  - Stimulus: hbusreq=4'b0110, t1=t2=7.
  - Response: hgrant=4'b0010.
- Tenure expiry:
  - Stimulus: master 0 holds its request; master 1 requests continuously with t1 > t0.
  - Response: master 0 keeps the grant for 8 hready cycles, then hgrant=4'b0010.
- Starvation:
  - Stimulus: master 3 requests with t3=0 for 12 cycles while masters 0/1 alternate with larger tickets.
  - Response: master 3 is granted at the first re-arbitration after wait[3]>=12.
- Lock and hready stall:
  - Stimulus: owner 1 asserts hlock[1]; masters 0/2/3 request; tenure exceeds 8; hready=0 for 3 cycles.
  - Response: hgrant stays 4'b0010 throughout and hmastlock=1. After hlock[1] drops with hready=1, the grant moves to the lottery winner.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the AHB lottery arbiter.
// Masters are identified by a 2-bit index; grants are one-hot.
package ahb_arb_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int TICKET_W    = 4;
  localparam int IDX_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Converts a one-hot grant into a master index.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lottery_pick.sv
// Combinational winner selection for the lottery arbiter.
// A starving requester beats any ticket; otherwise the largest ticket wins.
module lottery_pick
  import ahb_arb_pkg::*;
#(
  parameter int WAIT_W         = 4,
  parameter int STARVE_LIMIT   = 12,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic [NUM_MASTERS-1:0][TICKET_W-1:0] tickets,
  input  logic [NUM_MASTERS-1:0]               req,
  input  logic [NUM_MASTERS-1:0][WAIT_W-1:0]   wait_cnt,
  output logic [IDX_W-1:0]                     winner,
  output logic                                 any_req
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  logic                starved;
  logic [IDX_W-1:0]    starve_idx;
  logic                found;
  logic [IDX_W-1:0]    best_idx;
  logic [TICKET_W-1:0] best_t;

  // Descending scan for starvation leaves the lowest index; ascending scan
  // with a strict compare keeps the lowest index on ticket ties.
  always_comb begin
    starved    = 1'b0;
    starve_idx = '0;
    found      = 1'b0;
    best_idx   = IDX_W'(DEFAULT_MASTER);
    best_t     = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i] && (wait_cnt[i] >= LIMIT)) begin
        starved    = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (req[i] && (!found || (tickets[i] > best_t))) begin
        found    = 1'b1;
        best_idx = IDX_W'(i);
        best_t   = tickets[i];
      end
    end
  end

  assign any_req = |req;
  assign winner  = starved ? starve_idx : best_idx;

endmodule

// File: rtl/lottery_arbiter.sv
// AHB-style 4-master arbiter: lottery tickets pick the owner, with tenure
// limit, locked transfers and a starvation guard.
module lottery_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int MAX_TENURE     = 8,
  parameter int STARVE_LIMIT   = 12,
  parameter int WAIT_W         = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TICKET_W-1:0]    t0,
  input  logic [TICKET_W-1:0]    t1,
  input  logic [TICKET_W-1:0]    t2,
  input  logic [TICKET_W-1:0]    t3,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [IDX_W-1:0]       hmaster,
  output logic                   hmastlock
);

  localparam int TEN_W = $clog2(MAX_TENURE + 1);
  localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(MAX_TENURE - 1);
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  state_t                           state, state_n;
  logic [TEN_W-1:0]                 tenure, tenure_n;
  logic [NUM_MASTERS-1:0]           grant_n;
  logic [NUM_MASTERS-1:0][WAIT_W-1:0] wait_cnt;
  logic [IDX_W-1:0]                 winner, owner;
  logic                             any_req, others_req;
  logic [NUM_MASTERS-1:0]           win_grant;

  lottery_pick #(
    .WAIT_W        (WAIT_W),
    .STARVE_LIMIT  (STARVE_LIMIT),
    .DEFAULT_MASTER(DEFAULT_MASTER)
  ) u_pick (
    .tickets (({t3, t2, t1, t0})),
    .req     (hbusreq),
    .wait_cnt(wait_cnt),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner      = onehot_idx(hgrant);
  assign others_req = |(hbusreq & ~hgrant);
  assign win_grant  = NUM_MASTERS'(1) << winner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tenure    <= '0;
      hgrant    <= DEFAULT_GRANT;
      hmaster   <= IDX_W'(DEFAULT_MASTER);
      hmastlock <= 1'b0;
    end else begin
      state  <= state_n;
      tenure <= tenure_n;
      hgrant <= grant_n;
      if (hready) begin
        hmaster   <= owner;
        hmastlock <= hlock[owner] && (state == ST_LOCKED);
      end
    end
  end

  // A dropped request takes priority over tenure expiry; both re-arbitrate.
  always_comb begin
    state_n  = state;
    grant_n  = hgrant;
    tenure_n = tenure;
    if (hready) begin
      case (state)
        ST_IDLE: begin
          tenure_n = '0;
          if (any_req) begin
            grant_n = win_grant;
            state_n = hlock[winner] ? ST_LOCKED : ST_OWN;
          end else begin
            grant_n = DEFAULT_GRANT;
          end
        end
        ST_OWN: begin
          if (hlock[owner]) begin
            state_n = ST_LOCKED;
          end else if (!hbusreq[owner] || ((tenure == TEN_LAST) && others_req)) begin
            tenure_n = '0;
            if (any_req) begin
              grant_n = win_grant;
              state_n = ST_OWN;
            end else begin
              grant_n = DEFAULT_GRANT;
              state_n = ST_IDLE;
            end
          end else if (tenure != '1) begin
            tenure_n = tenure + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!hlock[owner]) begin
            tenure_n = '0;
            state_n  = ST_OWN;
          end
        end
        default: begin
          state_n  = ST_IDLE;
          grant_n  = DEFAULT_GRANT;
          tenure_n = '0;
        end
      endcase
    end
  end

  // Wait counters run every cycle, independent of hready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (hbusreq[i] && !hgrant[i]) begin
          if (wait_cnt[i] != '1) wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lottery_arbiter.sv
// Directed self-checking bench for lottery_arbiter: reset, ticket choice,
// tie-break, tenure expiry, starvation, locking with hready stalls.
module tb_lottery_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] t0 = '0, t1 = '0, t2 = '0, t3 = '0;
  logic [3:0] hbusreq = '0, hlock = '0;
  logic       hready = 1'b1;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int checks = 0;
  int errors = 0;

  lottery_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .t0       (t0),
    .t1       (t1),
    .t2       (t2),
    .t3       (t3),
    .hbusreq  (hbusreq),
    .hlock    (hlock),
    .hready   (hready),
    .hgrant   (hgrant),
    .hmaster  (hmaster),
    .hmastlock(hmastlock)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Holds reset low across one clock edge with all inputs idle, then releases.
  task automatic do_reset();
    reset   = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    hready  = 1'b1;
    t0 = '0; t1 = '0; t2 = '0; t3 = '0;
    tick(1);
    reset = 1'b1;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check_output("rst_grant",  hgrant, 4'b0001);
    check_output("rst_master", {2'b00, hmaster}, 4'd0);
    check_output("rst_lock",   {3'b000, hmastlock}, 4'd0);
    tick(1);
    reset = 1'b1;

    hbusreq = 4'b1010; t1 = 4'd5; t3 = 4'd9;
    tick(1);
    check_output("ticket_grant",    hgrant, 4'b1000);
    check_output("ticket_mst_lag",  {2'b00, hmaster}, 4'd0);
    tick(1);
    check_output("ticket_mst",      {2'b00, hmaster}, 4'd3);
    check_output("ticket_mastlock", {3'b000, hmastlock}, 4'd0);
    hbusreq = 4'b0000;
    tick(1);
    check_output("drop_to_default", hgrant, 4'b0001);

    do_reset();
    hbusreq = 4'b0110; t1 = 4'd7; t2 = 4'd7;
    tick(1);
    check_output("tie_break", hgrant, 4'b0010);

    do_reset();
    hbusreq = 4'b0001;
    tick(1);
    check_output("tenure_own0", hgrant, 4'b0001);
    hbusreq = 4'b0011; t0 = 4'd2; t1 = 4'd10;
    tick(7);
    check_output("tenure_hold", hgrant, 4'b0001);
    tick(1);
    check_output("tenure_expire", hgrant, 4'b0010);
    check_output("tenure_mst_lag", {2'b00, hmaster}, 4'd0);
    tick(1);
    check_output("tenure_mst", {2'b00, hmaster}, 4'd1);

    do_reset();
    hbusreq = 4'b1011; t0 = 4'd5; t1 = 4'd6; t3 = 4'd0;
    tick(1);
    check_output("starve_first", hgrant, 4'b0010);
    tick(7);
    check_output("starve_hold1", hgrant, 4'b0010);
    t0 = 4'd9;
    tick(1);
    check_output("starve_alt0", hgrant, 4'b0001);
    t1 = 4'd10;
    tick(7);
    check_output("starve_hold0", hgrant, 4'b0001);
    tick(1);
    check_output("starve_win3", hgrant, 4'b1000);

    do_reset();
    hbusreq = 4'b0010; hlock = 4'b0010; t1 = 4'd1;
    tick(1);
    check_output("lock_grant", hgrant, 4'b0010);
    check_output("lock_ml_lag", {3'b000, hmastlock}, 4'd0);
    hbusreq = 4'b1111; t0 = 4'd1; t2 = 4'd2; t3 = 4'd15;
    tick(1);
    check_output("lock_mastlock", {3'b000, hmastlock}, 4'd1);
    check_output("lock_master", {2'b00, hmaster}, 4'd1);
    tick(10);
    check_output("lock_past_tenure", hgrant, 4'b0010);
    hready = 1'b0; hlock = 4'b0000; hbusreq = 4'b1101;
    tick(3);
    check_output("stall_grant", hgrant, 4'b0010);
    check_output("stall_mastlock", {3'b000, hmastlock}, 4'd1);
    hready = 1'b1;
    tick(1);
    check_output("unlock_grant", hgrant, 4'b0010);
    check_output("unlock_mastlock", {3'b000, hmastlock}, 4'd0);
    tick(1);
    check_output("unlock_rearb", hgrant, 4'b0001);

    do_reset();
    hbusreq = 4'b0100; hlock = 4'b0100;
    tick(2);
    check_output("burst_grant", hgrant, 4'b0100);
    check_output("burst_mastlock", {3'b000, hmastlock}, 4'd1);
    #2 reset = 1'b0;
    #1;
    check_output("midrst_grant", hgrant, 4'b0001);
    check_output("midrst_master", {2'b00, hmaster}, 4'd0);
    check_output("midrst_lock", {3'b000, hmastlock}, 4'd0);
    hbusreq = '0; hlock = '0;
    tick(1);
    reset = 1'b1;
    tick(2);
    check_output("post_rst_idle", hgrant, 4'b0001);
    hbusreq = 4'b0100;
    tick(1);
    check_output("post_rst_req", hgrant, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
